// File: rtl/sdram_req_mux.sv
// rtl/sdram_req_mux.sv - 8-cycle slot arbiter and read capture in front of the sdram controller
// Optional loader port enabled by defining SDRAM_MUX_LOADER_EN.
module sdram_req_mux #(
    parameter int ADDR_W      = 25,
    parameter int CAPTURE_DLY = 7
) (
    input  logic              clk,
    input  logic              init_n,
    input  logic              clkref,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_aux,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    output logic              cpu_done,
    input  logic              ld_wr,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic              ld_aux,
    input  logic [7:0]        ld_din,
    output logic              ld_busy,
    output logic              ld_ovf,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic              ram_aux,
    output logic [7:0]        ram_din,
    input  logic [15:0]       ram_dout
);

    typedef enum logic [1:0] {OWN_IDLE, OWN_CPU, OWN_LOAD} owner_t;

    localparam bit       CAP_OK = (CAPTURE_DLY >= 0) && (CAPTURE_DLY <= 7);
    localparam logic [2:0] CAP3 = 3'(CAPTURE_DLY);

    logic              ref_q1, ref_q2;
    logic              slot_start;
    logic [2:0]        ph;
    owner_t            owner, owner_nxt;
    logic              load_pend;
    logic [ADDR_W-1:0] buf_addr;
    logic              buf_aux;
    logic [7:0]        buf_din;
    logic              cap_fire, cap_we, cap_aux;

    assign slot_start = ref_q1 & ~ref_q2;

`ifdef SDRAM_MUX_LOADER_EN
    logic busy_q, ovf_q;

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            busy_q   <= 1'b0;
            ovf_q    <= 1'b0;
            buf_addr <= '0;
            buf_aux  <= 1'b0;
            buf_din  <= '0;
        end else begin
            if (slot_start && busy_q)
                busy_q <= 1'b0;
            if (ld_wr) begin
                if (busy_q) begin
                    ovf_q <= 1'b1;
                end else begin
                    buf_addr <= ld_addr;
                    buf_aux  <= ld_aux;
                    buf_din  <= ld_din;
                    busy_q   <= 1'b1;
                end
            end
        end
    end

    assign load_pend = busy_q;
    assign ld_busy   = busy_q;
    assign ld_ovf    = ovf_q;
`else
    logic unused_ld;
    assign unused_ld = ^{ld_wr, ld_addr, ld_aux, ld_din};
    assign load_pend = 1'b0;
    assign buf_addr  = '0;
    assign buf_aux   = 1'b0;
    assign buf_din   = '0;
    assign ld_busy   = 1'b0;
    assign ld_ovf    = 1'b0;
`endif

    always_comb begin
        owner_nxt = OWN_IDLE;
        if (load_pend)
            owner_nxt = OWN_LOAD;
        else if (cpu_req)
            owner_nxt = OWN_CPU;
    end

    // Capture fires on the edge that moves ph onto CAPTURE_DLY, so cpu_done is high while ph == CAPTURE_DLY.
    always_comb begin
        cap_fire = 1'b0;
        cap_we   = ram_we;
        cap_aux  = ram_aux;
        if (slot_start) begin
            cap_fire = CAP_OK && (CAP3 == 3'd0) && (owner_nxt == OWN_CPU);
            cap_we   = cpu_we;
            cap_aux  = cpu_aux;
        end else begin
            cap_fire = CAP_OK && (owner == OWN_CPU) && (ph != 3'd7) && ((ph + 3'd1) == CAP3);
        end
    end

    // Synchroniser resets high so a clkref already high at release does not open a slot.
    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            ref_q1   <= 1'b1;
            ref_q2   <= 1'b1;
            ph       <= 3'd7;
            owner    <= OWN_IDLE;
            ram_addr <= '0;
            ram_we   <= 1'b0;
            ram_aux  <= 1'b0;
            ram_din  <= '0;
            cpu_dout <= '0;
            cpu_done <= 1'b0;
        end else begin
            ref_q1   <= clkref;
            ref_q2   <= ref_q1;
            cpu_done <= cap_fire;
            if (cap_fire && !cap_we)
                cpu_dout <= cap_aux ? ram_dout[7:0] : ram_dout[15:8];
            if (slot_start) begin
                ph    <= 3'd0;
                owner <= owner_nxt;
                case (owner_nxt)
                    OWN_LOAD: begin
                        ram_addr <= buf_addr;
                        ram_we   <= 1'b1;
                        ram_aux  <= buf_aux;
                        ram_din  <= buf_din;
                    end
                    OWN_CPU: begin
                        ram_addr <= cpu_addr;
                        ram_we   <= cpu_we;
                        ram_aux  <= cpu_aux;
                        ram_din  <= cpu_din;
                    end
                    default: ram_we <= 1'b0;
                endcase
            end else if (ph != 3'd7) begin
                ph <= ph + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_req_mux.sv
// tb/tb_sdram_req_mux.sv - directed self-checking bench for sdram_req_mux
`timescale 1ns/1ps
module tb_sdram_req_mux;

    logic        clk = 1'b0;
    logic        init_n;
    logic        clkref = 1'b0;
    logic        cpu_req, cpu_we, cpu_aux;
    logic [24:0] cpu_addr;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        cpu_done;
    logic        ld_wr, ld_aux;
    logic [24:0] ld_addr;
    logic [7:0]  ld_din;
    logic        ld_busy, ld_ovf;
    logic [24:0] ram_addr;
    logic        ram_we, ram_aux;
    logic [7:0]  ram_din;
    logic [15:0] ram_dout;

    int total = 0;
    int bad   = 0;

    sdram_req_mux #(.ADDR_W(25), .CAPTURE_DLY(7)) dut (
        .clk(clk), .init_n(init_n), .clkref(clkref),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_aux(cpu_aux),
        .cpu_din(cpu_din), .cpu_dout(cpu_dout), .cpu_done(cpu_done),
        .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_aux(ld_aux), .ld_din(ld_din),
        .ld_busy(ld_busy), .ld_ovf(ld_ovf),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_aux(ram_aux), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    // clk rises at 5+10k; clkref rises at 42+80k, never on a clk edge
    always #5 clk = ~clk;
    initial begin
        #2;
        forever #40 clkref = ~clkref;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [24:0] addr,
                           input logic aux, input logic [7:0] din);
        cpu_req  = req;
        cpu_we   = we;
        cpu_addr = addr;
        cpu_aux  = aux;
        cpu_din  = din;
    endtask

    // returns 1 ns after the slot_start edge (ph = 0)
    task automatic sync_slot();
        @(posedge clkref);
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_ld(input logic [24:0] addr, input logic aux, input logic [7:0] din);
        ld_addr = addr;
        ld_aux  = aux;
        ld_din  = din;
        ld_wr   = 1'b1;
        @(posedge clk);
        #1;
        ld_wr   = 1'b0;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ram_addr"}, 32'(ram_addr), 32'h0);
        chk({tag, "_ram_we"},   32'(ram_we),   32'h0);
        chk({tag, "_ram_aux"},  32'(ram_aux),  32'h0);
        chk({tag, "_ram_din"},  32'(ram_din),  32'h0);
        chk({tag, "_cpu_dout"}, 32'(cpu_dout), 32'h0);
        chk({tag, "_cpu_done"}, 32'(cpu_done), 32'h0);
        chk({tag, "_ld_busy"},  32'(ld_busy),  32'h0);
        chk({tag, "_ld_ovf"},   32'(ld_ovf),   32'h0);
    endtask

    initial begin
        init_n   = 1'b0;
        set_cpu(1'b0, 1'b0, 25'h0, 1'b0, 8'h00);
        ld_wr    = 1'b0;
        ld_addr  = '0;
        ld_aux   = 1'b0;
        ld_din   = '0;
        ram_dout = 16'h0000;

        #1;
        chk_reset_vals("rst");
        step(2);
        init_n = 1'b1;

        // idle traffic: two full slots without any request
        sync_slot();
        for (int i = 0; i < 16; i++) begin
            chk("idle_we", 32'(ram_we), 32'h0);
            chk("idle_done", 32'(cpu_done), 32'h0);
            step(1);
        end

        // CPU read, low lane
        set_cpu(1'b1, 1'b0, 25'h00C000, 1'b1, 8'h00);
        ram_dout = 16'hA55A;
        sync_slot();
        cpu_req = 1'b0;
        chk("rd1_addr", 32'(ram_addr), 32'h0000C000);
        chk("rd1_we",   32'(ram_we),   32'h0);
        chk("rd1_aux",  32'(ram_aux),  32'h1);
        step(6);
        chk("rd1_done_early", 32'(cpu_done), 32'h0);
        step(1);
        chk("rd1_done", 32'(cpu_done), 32'h1);
        chk("rd1_dout", 32'(cpu_dout), 32'h5A);
        step(1);
        chk("rd1_done_off", 32'(cpu_done), 32'h0);

        // CPU read, high lane
        set_cpu(1'b1, 1'b0, 25'h00C000, 1'b0, 8'h00);
        sync_slot();
        cpu_req = 1'b0;
        chk("rd0_aux", 32'(ram_aux), 32'h0);
        step(7);
        chk("rd0_done", 32'(cpu_done), 32'h1);
        chk("rd0_dout", 32'(cpu_dout), 32'hA5);

        // CPU write: outputs stable for 8 clk, cpu_dout untouched
        set_cpu(1'b1, 1'b1, 25'h000400, 1'b1, 8'h3C);
        sync_slot();
        cpu_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("wr_we",   32'(ram_we),   32'h1);
            chk("wr_din",  32'(ram_din),  32'h3C);
            chk("wr_addr", 32'(ram_addr), 32'h00000400);
            if (i < 7) step(1);
        end
        chk("wr_done", 32'(cpu_done), 32'h1);
        chk("wr_dout", 32'(cpu_dout), 32'hA5);
        step(1);
        chk("wr_next_idle_we", 32'(ram_we), 32'h0);
        chk("wr_next_idle_addr", 32'(ram_addr), 32'h00000400);

        // loader write vs CPU request
        sync_slot();
        pulse_ld(25'h01D000, 1'b1, 8'h77);
`ifdef SDRAM_MUX_LOADER_EN
        chk("ld_busy_set", 32'(ld_busy), 32'h1);
        chk("ld_ovf_clear", 32'(ld_ovf), 32'h0);
        pulse_ld(25'h01E000, 1'b0, 8'h99);
        chk("ld_ovf_set", 32'(ld_ovf), 32'h1);
        chk("ld_busy_hold", 32'(ld_busy), 32'h1);
        set_cpu(1'b1, 1'b0, 25'h00C000, 1'b1, 8'h00);
        step(6);
        chk("ld_slot_we",   32'(ram_we),   32'h1);
        chk("ld_slot_addr", 32'(ram_addr), 32'h0001D000);
        chk("ld_slot_aux",  32'(ram_aux),  32'h1);
        chk("ld_slot_din",  32'(ram_din),  32'h77);
        chk("ld_busy_drop", 32'(ld_busy),  32'h0);
        step(7);
        chk("ld_slot_no_done", 32'(cpu_done), 32'h0);
        step(1);
        chk("ld_cpu_addr", 32'(ram_addr), 32'h0000C000);
        chk("ld_cpu_we",   32'(ram_we),   32'h0);
        step(7);
        chk("ld_cpu_done", 32'(cpu_done), 32'h1);
        chk("ld_cpu_dout", 32'(cpu_dout), 32'h5A);
        cpu_req = 1'b0;
        chk("ld_ovf_sticky", 32'(ld_ovf), 32'h1);
`else
        chk("ld_busy_off", 32'(ld_busy), 32'h0);
        pulse_ld(25'h01E000, 1'b0, 8'h99);
        chk("ld_ovf_off", 32'(ld_ovf), 32'h0);
        step(6);
        chk("ld_ignored_we", 32'(ram_we), 32'h0);
        chk("ld_ignored_addr", 32'(ram_addr), 32'h00000400);
`endif

        // reset at ph=3 of a CPU read
        set_cpu(1'b1, 1'b0, 25'h001234, 1'b0, 8'h00);
        ram_dout = 16'h1E2D;
        sync_slot();
        step(3);
        chk("mid_addr", 32'(ram_addr), 32'h00001234);
        init_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("mid_rst_done", 32'(cpu_done), 32'h0);
        end
        init_n = 1'b1;
        @(posedge clkref);
        #1;
        chk("post_rst_noslot", 32'(ram_addr), 32'h0);
        step(2);
        chk("post_rst_addr", 32'(ram_addr), 32'h00001234);
        step(7);
        chk("post_rst_done", 32'(cpu_done), 32'h1);
        chk("post_rst_dout", 32'(cpu_dout), 32'h1E);
        cpu_req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
